// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register placed between two pipeline stages (ID/EX, EX/MEM,
// MEM/WB). It carries a data payload and a control payload across one stage
// with a valid/ready handshake. It also provides:
//   - a synchronous flush that turns the stage into a bubble,
//   - a saturating counter of back-pressured cycles.
//
// A beat is accepted on a rising edge with in_valid && in_ready. It leaves
// (drains) on a rising edge with out_valid && out_ready. Latency is one
// cycle. Throughput is one beat per cycle while out_ready stays high.
//
// Build option:
//   PIPE_SKID_EN  When defined, adds a one-entry skid buffer so that in_ready
//                 is a flop and no longer depends on out_ready. The stage then
//                 holds up to two beats. When undefined, the stage holds one
//                 beat and in_ready = !out_valid || out_ready (combinational).
//
// Parameters:
//   DATA_W  width of the data payload; flush leaves it unchanged
//   CTRL_W  width of the control payload; flush and bubbles force it to zero
//   CNT_W   width of the back-pressure counter
//
// Ports:
//   clk        single clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream data payload
//   in_ctrl    upstream control payload
//   out_valid  stage holds a valid beat
//   out_ready  downstream accepts the beat this cycle
//   out_data   registered data payload
//   out_ctrl   registered control payload, all-zero whenever out_valid=0
//   flush      synchronous kill of all held and incoming beats
//   stall_cnt  saturating count of edges with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Main register: the beat presented on out_*.
    logic  mv;
    logic  mv_nxt;
    beat_t main;
    beat_t main_nxt;

    beat_t in_beat;
    logic  accept;
    logic  drain;

    assign in_beat = '{data: in_data, ctrl: in_ctrl};
    assign accept  = in_valid && in_ready;
    assign drain   = mv && out_ready;

`ifdef PIPE_SKID_EN
    // -----------------------------------------------------------------------
    // Skid variant: a second entry catches the beat accepted while the main
    // register is full and stalled. in_ready is registered, so it can only
    // drop one cycle after the skid entry fills. That is why the skid entry
    // must exist at all.
    // -----------------------------------------------------------------------
    logic  sv;
    logic  sv_nxt;
    logic  skid_load;
    logic  rdy_q;
    beat_t skid;

    assign in_ready = rdy_q;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        mv_nxt    = mv;
        main_nxt  = main;
        sv_nxt    = sv;
        skid_load = 1'b0;

        if (flush) begin
            // Bubble: drop everything held and anything accepted this edge.
            // Data is left as-is; only control must read as zero.
            mv_nxt        = 1'b0;
            main_nxt.ctrl = '0;
            sv_nxt        = 1'b0;
        end else if (sv) begin
            // Two beats held (sv implies mv). Only a drain moves anything.
            // The skid beat is older than any incoming beat, so it goes to
            // the main register first.
            if (drain) begin
                main_nxt  = skid;
                sv_nxt    = accept;
                skid_load = accept;
            end
        end else if (accept) begin
            if (!mv || drain) begin
                mv_nxt   = 1'b1;
                main_nxt = in_beat;
            end else begin
                // Main register full and stalled: park the beat in the skid.
                sv_nxt    = 1'b1;
                skid_load = 1'b1;
            end
        end else if (drain) begin
            mv_nxt        = 1'b0;
            main_nxt.ctrl = '0;
        end
    end

    // in_ready mirrors "skid empty" for the coming cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv    <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            sv    <= sv_nxt;
            rdy_q <= !sv_nxt;
        end
    end

    // NOTE: the skid payload has no reset. It is only read while sv=1, and sv
    // is reset, so leaving reset off this storage loses nothing.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid <= in_beat;
        end
    end

`else
    // -----------------------------------------------------------------------
    // Plain variant: one entry. A new beat may enter whenever the held one is
    // leaving in the same cycle. This makes in_ready combinational from
    // out_ready.
    // -----------------------------------------------------------------------
    assign in_ready = !mv || out_ready;

    always_comb begin
        mv_nxt   = mv;
        main_nxt = main;

        if (flush) begin
            mv_nxt        = 1'b0;
            main_nxt.ctrl = '0;
        end else if (accept) begin
            // accept already implies the register is empty or draining.
            mv_nxt   = 1'b1;
            main_nxt = in_beat;
        end else if (drain) begin
            mv_nxt        = 1'b0;
            main_nxt.ctrl = '0;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Main register. ctrl is kept at zero whenever mv=0, so out_ctrl needs no
    // gating.
    // -----------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so that every
    // flop samples the pre-edge values, whatever the order of evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv   <= 1'b0;
            main <= '0;
        end else begin
            mv   <= mv_nxt;
            main <= main_nxt;
        end
    end

    assign out_valid = mv;
    assign out_data  = main.data;
    assign out_ctrl  = main.ctrl;

    // -----------------------------------------------------------------------
    // Back-pressure counter. It counts every edge on which a held beat was
    // refused, including flush edges. It sticks at all-ones and is cleared
    // only by rst.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (mv && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. A queue-based model of the stage
// (held beats in arrival order, last main-register data, saturating stall
// count) predicts every output. The model is compared against the DUT on
// every falling edge. Directed sequences add literal expectations for
// latency, ordering, stability, flush, saturation and asynchronous reset.
// It works with and without PIPE_SKID_EN.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 48;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;
    localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: a FIFO of held beats, front = what out_* shows.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    beat_t             mq[$];
    logic [DATA_W-1:0] m_last  = '0;
    int unsigned       m_stall = 0;

    function automatic bit m_ready();
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit acc;
        bit drn;
        if (rst) begin
            mq.delete();
            m_last  = '0;
            m_stall = 0;
        end else begin
            acc = in_valid && m_ready();
            drn = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready && (m_stall < STALL_MAX))
                m_stall++;
            if (drn)
                void'(mq.pop_front());
            if (flush)
                mq.delete();
            else if (acc)
                mq.push_back('{data: in_data, ctrl: in_ctrl});
            if (mq.size() > 0)
                m_last = mq[0].data;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cmp_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("cmp_out_data", 64'(out_data), 64'(m_last));
        check("cmp_out_ctrl", 64'(out_ctrl),
              (mq.size() > 0) ? 64'(mq[0].ctrl) : 64'd0);
        check("cmp_in_ready", 64'(in_ready), 64'(m_ready()));
        check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    end

    // Log of delivered beats (pre-edge values, sampled before NBAs settle).
    int                cyc = 0;
    logic [DATA_W-1:0] got_data[$];
    int                got_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------------
    initial begin : stim
        int base;
        #1 rst = 1'b1;
        #11 rst = 1'b0;               // released between edges (t=12)

        // Reset values
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1) Stream 1..5 with out_ready=1
        base      = got_data.size();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 48'h000001;
        in_ctrl   = 8'h01;
        tick();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'h000001);
        for (int i = 2; i <= 5; i++) begin
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_count", 64'(got_data.size() - base), 64'd5);
        if (got_data.size() - base == 5) begin
            for (int i = 0; i < 5; i++)
                check("stream_order", 64'(got_data[base+i]), 64'(i + 1));
            for (int i = 1; i < 5; i++)
                check("stream_gap", 64'(got_cyc[base+i] - got_cyc[base+i-1]), 64'd1);
        end
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // 2) Hold 0x00ABCD / 0x81 for 10 back-pressured cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h00ABCD;
        in_ctrl   = 8'h81;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_data", 64'(out_data), 64'h00ABCD);
            check("hold_ctrl", 64'(out_ctrl), 64'h81);
`ifdef PIPE_SKID_EN
            check("hold_in_ready", 64'(in_ready), 64'd1);
`else
            check("hold_in_ready", 64'(in_ready), 64'd0);
`endif
        end
        check("hold_stall", 64'(stall_cnt), 64'd10);
        out_ready = 1'b1;
        tick();
        check("hold_drained", 64'(out_valid), 64'd0);
        check("hold_stall_kept", 64'(stall_cnt), 64'd10);

        // 3) Push A, B (and C offered while full) under back-pressure
        base      = got_data.size();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h11;
        in_ctrl   = 8'h0A;
        tick();
        in_data = 48'h22;
        in_ctrl = 8'h0B;
        tick();
        check("ab_in_ready_full", 64'(in_ready), 64'd0);
        check("ab_front", 64'(out_data), 64'h11);
        in_data = 48'h33;
        in_ctrl = 8'h0C;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
`ifdef PIPE_SKID_EN
        check("ab_second", 64'(out_data), 64'h22);
        check("ab_second_valid", 64'(out_valid), 64'd1);
        check("ab_in_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("ab_count", 64'(got_data.size() - base), 64'd2);
        if (got_data.size() - base == 2) begin
            check("ab_first_out", 64'(got_data[base]), 64'h11);
            check("ab_second_out", 64'(got_data[base+1]), 64'h22);
            check("ab_gap", 64'(got_cyc[base+1] - got_cyc[base]), 64'd1);
        end
`else
        check("ab_empty", 64'(out_valid), 64'd0);
        tick();
        check("ab_count", 64'(got_data.size() - base), 64'd1);
        if (got_data.size() - base == 1)
            check("ab_first_out", 64'(got_data[base]), 64'h11);
`endif
        check("ab_idle", 64'(out_valid), 64'd0);

        // 4a) Flush while holding ctrl=0xFF, beat offered in the flush cycle
        base      = got_data.size();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h5A5A;
        in_ctrl   = 8'hFF;
        tick();
        check("fl_pre_ctrl", 64'(out_ctrl), 64'hFF);
        flush   = 1'b1;
        in_data = 48'h7777;
        in_ctrl = 8'h3C;
        tick();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'h00);
        check("fl_out_data", 64'(out_data), 64'h5A5A);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_ghost", 64'(out_valid), 64'd0);
        check("fl_none_out", 64'(got_data.size() - base), 64'd0);

        // 4b) Flush coinciding with a drain: the held beat is still delivered
        base     = got_data.size();
        in_valid = 1'b1;
        in_data  = 48'h6B6B;
        in_ctrl  = 8'h81;
        tick();
        flush   = 1'b1;
        in_data = 48'h8888;
        in_ctrl = 8'h42;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fld_out_valid", 64'(out_valid), 64'd0);
        check("fld_out_data", 64'(out_data), 64'h6B6B);
        tick();
        check("fld_count", 64'(got_data.size() - base), 64'd1);
        if (got_data.size() - base == 1)
            check("fld_delivered", 64'(got_data[base]), 64'h6B6B);

        // 5) Saturation of stall_cnt
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h123;
        in_ctrl   = 8'h05;
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        check("sat_value", 64'(stall_cnt), 64'hFFFF);
        check("sat_data", 64'(out_data), 64'h123);
        tick();
        check("sat_no_wrap", 64'(stall_cnt), 64'hFFFF);

        // 6) Asynchronous reset mid-stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 48'h900 + DATA_W'(i);
            in_ctrl = 8'hC0 + CTRL_W'(i);
            tick();
        end
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        check("ar_pre_data", 64'(out_data), 64'h902);
        #2 rst = 1'b1;                // between edges
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_ctrl", 64'(out_ctrl), 64'd0);
        check("ar_out_data", 64'(out_data), 64'd0);
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        #10 rst = 1'b0;
        tick();
        tick();
        check("ar_after_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
